vector_load_unit: RTL and testbench
===================================

# vector_load_unit

Multi-cycle vector load engine for the vector datapath. On a start request it reads LANES consecutive bytes from the byte-wide data RAM read port, one address per cycle. It assembles the bytes into one LANES×LANE_WIDTH vector and issues a single write-back to the vector register file. It is the read-side counterpart of the vector memory store path: it unpacks memory into a vector register using the same lane ordering the vector ALUs and store path use (lane 0 = bits [7:0]).

## Interface
- LANES, 16, number of lanes per vector
- LANE_WIDTH, 8, bits per lane (= RAM data width)
- ADDR_WIDTH, 12, RAM address width
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-low; one clock; reset is synchronous and active-low
- start  input  1  load request, sampled only in IDLE
- base_address  input  ADDR_WIDTH  address of lane 0, captured with start
- rd_in  input  5  destination vector register, captured with start
- mem_read_en  output  1  high while an address is being issued
- mem_address  output  ADDR_WIDTH  RAM read address
- mem_q  input  LANE_WIDTH  RAM read data, valid one cycle after its address (registered RAM)
- busy  output  1  high in every non-IDLE state
- stall  output  1  pipeline stall request to fetch/decode; equals busy
- vector_wre_out  output  1  one-cycle vector register write enable
- vector_rd_out  output  5  destination register, valid while vector_wre_out=1
- vector_data_out  output  LANES*LANE_WIDTH  assembled vector, held until next load completes
- done  output  1  one-cycle completion pulse, coincident with vector_wre_out

## Operation
- States: IDLE, FETCH, DRAIN, WRITE.
- IDLE: outputs idle. If start=1, capture base_address and rd_in, clear lane counter, and go to FETCH.
- FETCH: mem_read_en=1. mem_address = (base + cnt) mod 2^ADDR_WIDTH, so addresses wrap at 0xFFF→0x000. cnt runs 0..LANES-1. In every FETCH cycle with cnt≥1, lane cnt-1 ← mem_q. After cnt=LANES-1, go to DRAIN.
- DRAIN: mem_read_en=0. Lane LANES-1 ← mem_q. Go to WRITE.
- WRITE: vector_wre_out=1, done=1, vector_rd_out=captured rd. vector_data_out is updated from the assembly buffer at the end of DRAIN, so it is already valid here. Go to IDLE.
- Lane i occupies bits [i*LANE_WIDTH+LANE_WIDTH-1 : i*LANE_WIDTH].
- start while busy is ignored; there is no queuing.
- The assembly buffer is separate from vector_data_out, so a load in progress never disturbs the previously delivered vector.
- reset=0 in any state, including mid-load: next state IDLE, counter 0, the in-flight load is discarded, and no write-back occurs.

## Timing
- Reset values: mem_read_en=0, mem_address=0, busy=0, stall=0, vector_wre_out=0, done=0, vector_rd_out=0, vector_data_out=0.
- Cycle 0: start=1 is seen in IDLE.
- Cycles 1..LANES: FETCH, addresses base..base+LANES-1.
- Cycle LANES+1: DRAIN.
- Cycle LANES+2: WRITE.
- For the default parameters, write-back occurs in cycle 18 and the unit is back in IDLE at cycle 19, where it can accept a new start. The fixed latency of LANES+2 is independent of the data.
- busy/stall is high in cycles 1..LANES+2 inclusive. It drops in the same cycle the unit returns to IDLE.
- All outputs are registered or decoded from the state register only. There is no combinational path from start or mem_q to any output.

## Test plan
- Reset, then idle with start=0 → all outputs 0; mem_read_en stays 0 for 20 cycles.
- RAM[0x010+i]=i+0xA0, start with base=0x010, rd=3 → addresses 0x010..0x01F issued in cycles 1–16; cycle 18 vector_wre_out=1, rd=3, vector_data_out=0xAFAEAD…A1A0; busy high in exactly cycles 1–18.
- Wrap: base=0xFF8, RAM[0xFF8..0xFFF]=0x11, RAM[0x000..0x007]=0x22 → addresses wrap to 0x000 at the 9th issue; lanes 0–7=0x11, lanes 8–15=0x22.
- Pulse start again in cycle 5 with base=0x100 → ignored; the result matches the first load and the next FETCH begins only after a new start in IDLE.
- Back-to-back: start held high continuously → second load begins with its first address in cycle 20; two write-backs occur, in cycles 18 and 37; vector_data_out holds the first vector until the second WRITE.
- Reset asserted in cycle 10 of a load → IDLE next cycle, no vector_wre_out, vector_data_out=0; a subsequent load completes correctly.

Source files
------------

// File: rtl/vector_load_unit.sv
// vector_load_unit
//
// Multi-cycle vector load engine. A start request in IDLE captures a base
// address and a destination register. The unit then reads LANES consecutive
// bytes from a registered byte-wide RAM, one address per cycle, and packs them
// into one vector (lane 0 in the least significant byte). It finishes with a
// single one-cycle write-back to the vector register file.
//
// Ports
//   clk             system clock, rising-edge active
//   reset           synchronous, active-low reset
//   start           load request, only honoured in IDLE
//   base_address    address of lane 0, captured with start
//   rd_in           destination vector register, captured with start
//   mem_read_en     high while a RAM address is being issued
//   mem_address     RAM read address, wraps modulo 2^ADDR_WIDTH
//   mem_q           RAM read data, valid one cycle after its address
//   busy / stall    high in every non-IDLE state
//   vector_wre_out  one-cycle register-file write enable
//   vector_rd_out   destination register, valid with vector_wre_out
//   vector_data_out assembled vector, held until the next load completes
//   done            one-cycle completion pulse, coincident with write-back

module vector_load_unit #(
  parameter int LANES      = 16,
  parameter int LANE_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [ADDR_WIDTH-1:0]         base_address,
  input  logic [4:0]                    rd_in,
  output logic                          mem_read_en,
  output logic [ADDR_WIDTH-1:0]         mem_address,
  input  logic [LANE_WIDTH-1:0]         mem_q,
  output logic                          busy,
  output logic                          stall,
  output logic                          vector_wre_out,
  output logic [4:0]                    vector_rd_out,
  output logic [LANES*LANE_WIDTH-1:0]   vector_data_out,
  output logic                          done
);

  localparam int CNT_WIDTH = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(LANES - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    WRITE
  } state_t;

  state_t state;
  state_t state_next;

  logic [CNT_WIDTH-1:0]  cnt;
  logic [ADDR_WIDTH-1:0] base_reg;
  logic [4:0]            rd_reg;

  // Assembly buffer, kept apart from vector_data_out so an in-flight load
  // never disturbs the vector delivered by the previous load.
  logic [LANE_WIDTH-1:0] lane_buf [LANES];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Every output is decoded from the state register and captured registers
  // only, so nothing combinational leaks from start or mem_q to an output.
  always_comb begin
    state_next     = state;
    mem_read_en    = 1'b0;
    mem_address    = '0;
    busy           = 1'b0;
    stall          = 1'b0;
    vector_wre_out = 1'b0;
    done           = 1'b0;
    vector_rd_out  = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        mem_read_en = 1'b1;
        mem_address = base_reg + ADDR_WIDTH'(cnt);
        busy        = 1'b1;
        stall       = 1'b1;
        if (cnt == LAST_CNT) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        busy       = 1'b1;
        stall      = 1'b1;
        state_next = WRITE;
      end
      WRITE: begin
        busy           = 1'b1;
        stall          = 1'b1;
        vector_wre_out = 1'b1;
        done           = 1'b1;
        vector_rd_out  = rd_reg;
        state_next     = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath. The RAM is registered, so the byte returned in a FETCH cycle
  // belongs to the address issued one cycle earlier (lane cnt-1). The last
  // lane arrives during DRAIN and goes straight into the output vector, which
  // is therefore already valid when WRITE raises the write enable.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt             <= '0;
      base_reg        <= '0;
      rd_reg          <= '0;
      vector_data_out <= '0;
      for (int i = 0; i < LANES; i++) begin
        lane_buf[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_reg <= base_address;
            rd_reg   <= rd_in;
            cnt      <= '0;
          end
        end
        FETCH: begin
          cnt <= cnt + 1'b1;
          if (cnt != '0) begin
            lane_buf[cnt - 1'b1] <= mem_q;
          end
        end
        DRAIN: begin
          for (int i = 0; i < LANES - 1; i++) begin
            vector_data_out[i*LANE_WIDTH +: LANE_WIDTH] <= lane_buf[i];
          end
          vector_data_out[(LANES-1)*LANE_WIDTH +: LANE_WIDTH] <= mem_q;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_load_unit.sv
// Testbench for vector_load_unit: directed scenarios with literal expectations
// plus randomized traffic, all checked every cycle against a transaction-level
// model (a load accepted at cycle 0 issues base+k in cycle k+1, writes back in
// cycle LANES+2 with the vector read from the RAM image).

module tb_vector_load_unit;

  localparam int LANES = 16;
  localparam int LW    = 8;
  localparam int AW    = 12;
  localparam int VW    = LANES * LW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_address;
  logic [4:0]    rd_in;
  logic          mem_read_en;
  logic [AW-1:0] mem_address;
  logic [LW-1:0] mem_q;
  logic          busy;
  logic          stall;
  logic          vector_wre_out;
  logic [4:0]    vector_rd_out;
  logic [VW-1:0] vector_data_out;
  logic          done;

  int total = 0;
  int bad   = 0;
  logic check_en = 1'b0;

  logic [LW-1:0] ram [1 << AW];

  vector_load_unit #(.LANES(LANES), .LANE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .base_address(base_address),
    .rd_in(rd_in),
    .mem_read_en(mem_read_en),
    .mem_address(mem_address),
    .mem_q(mem_q),
    .busy(busy),
    .stall(stall),
    .vector_wre_out(vector_wre_out),
    .vector_rd_out(vector_rd_out),
    .vector_data_out(vector_data_out),
    .done(done)
  );

  always #5 clk = ~clk;

  // Registered RAM: data appears one cycle after its address.
  always @(posedge clk) begin
    mem_q <= ram[mem_address];
  end

  task automatic checkOutput(input string name, input logic [VW-1:0] actual,
                             input logic [VW-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  function automatic logic [VW-1:0] build_vec(input logic [AW-1:0] b);
    logic [VW-1:0] v;
    logic [AW-1:0] a;
    v = '0;
    for (int i = 0; i < LANES; i++) begin
      a = b + AW'(i);
      v[i*LW +: LW] = ram[a];
    end
    return v;
  endfunction

  // Transaction-level model: phase counts cycles since the accepted start
  // (0 = idle). Vector contents come straight from the RAM image.
  int            phase = 0;
  logic [AW-1:0] m_base = '0;
  logic [4:0]    m_rd = '0;
  logic [VW-1:0] pend = '0;
  logic [VW-1:0] exp_vec = '0;

  always @(posedge clk) begin
    if (!reset) begin
      phase   <= 0;
      exp_vec <= '0;
    end else if (phase == 0) begin
      if (start) begin
        phase  <= 1;
        m_base <= base_address;
        m_rd   <= rd_in;
        pend   <= build_vec(base_address);
      end
    end else if (phase == LANES + 2) begin
      phase <= 0;
    end else begin
      phase <= phase + 1;
      if (phase == LANES + 1) begin
        exp_vec <= pend;
      end
    end
  end

  // Compare process: every cycle, away from the rising edge.
  always @(negedge clk) begin
    logic          e_en;
    logic [AW-1:0] e_addr;
    if (check_en) begin
      e_en   = (phase >= 1) && (phase <= LANES);
      e_addr = e_en ? m_base + AW'(phase - 1) : '0;
      checkOutput("model_read_en", VW'(mem_read_en), VW'(e_en));
      checkOutput("model_address", VW'(mem_address), VW'(e_addr));
      checkOutput("model_busy", VW'(busy), VW'(phase != 0));
      checkOutput("model_stall", VW'(stall), VW'(phase != 0));
      checkOutput("model_wre", VW'(vector_wre_out), VW'(phase == LANES + 2));
      checkOutput("model_done", VW'(done), VW'(phase == LANES + 2));
      checkOutput("model_data", vector_data_out, exp_vec);
      if (phase == LANES + 2) begin
        checkOutput("model_rd", VW'(vector_rd_out), VW'(m_rd));
      end
    end
  end

  // Drive one start pulse; returns positioned in cycle 1 of the load.
  task automatic applyStimulus(input logic [AW-1:0] b, input logic [4:0] r);
    start        = 1'b1;
    base_address = b;
    rd_in        = r;
    @(negedge clk);
    start = 1'b0;
  endtask

  int busy_cnt;
  int wre_cnt;

  initial begin
    reset        = 1'b0;
    start        = 1'b0;
    base_address = '0;
    rd_in        = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i] = LW'($urandom);
    end
    @(negedge clk);
    @(negedge clk);
    check_en = 1'b1;
    checkOutput("reset_read_en", VW'(mem_read_en), '0);
    checkOutput("reset_address", VW'(mem_address), '0);
    checkOutput("reset_busy", VW'(busy), '0);
    checkOutput("reset_wre", VW'(vector_wre_out), '0);
    checkOutput("reset_rd", VW'(vector_rd_out), '0);
    checkOutput("reset_data", vector_data_out, '0);
    reset = 1'b1;
    repeat (20) begin
      @(negedge clk);
      checkOutput("idle_read_en", VW'(mem_read_en), '0);
    end

    $display("[TB] basic load");
    for (int i = 0; i < LANES; i++) ram[12'h010 + i] = 8'hA0 + LW'(i);
    applyStimulus(12'h010, 5'd3);
    busy_cnt = 0;
    for (int c = 1; c <= 19; c++) begin
      if (busy) busy_cnt++;
      if (c == 1)  checkOutput("basic_addr_first", VW'(mem_address), VW'(12'h010));
      if (c == 16) checkOutput("basic_addr_last", VW'(mem_address), VW'(12'h01F));
      if (c == 17) checkOutput("basic_drain_read_en", VW'(mem_read_en), '0);
      if (c == 18) begin
        checkOutput("basic_wre", VW'(vector_wre_out), VW'(1'b1));
        checkOutput("basic_rd", VW'(vector_rd_out), VW'(5'd3));
        checkOutput("basic_vec", vector_data_out,
                    128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0);
      end
      @(negedge clk);
    end
    checkOutput("basic_busy_cycles", VW'(busy_cnt), VW'(18));

    $display("[TB] address wrap");
    for (int i = 0; i < 8; i++) begin
      ram[12'hFF8 + i] = 8'h11;
      ram[i]           = 8'h22;
    end
    applyStimulus(12'hFF8, 5'd7);
    for (int c = 1; c <= 18; c++) begin
      if (c == 8) checkOutput("wrap_addr_8", VW'(mem_address), VW'(12'hFFF));
      if (c == 9) checkOutput("wrap_addr_9", VW'(mem_address), VW'(12'h000));
      if (c == 18) checkOutput("wrap_vec", vector_data_out,
                               128'h2222222222222222_1111111111111111);
      @(negedge clk);
    end

    $display("[TB] start while busy");
    for (int i = 0; i < LANES; i++) begin
      ram[12'h020 + i] = 8'h30 + LW'(i);
      ram[12'h100 + i] = 8'hEE;
    end
    applyStimulus(12'h020, 5'd5);
    repeat (4) @(negedge clk);
    start        = 1'b1;
    base_address = 12'h100;
    rd_in        = 5'd1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("ignore_addr_c6", VW'(mem_address), VW'(12'h025));
    repeat (12) @(negedge clk);
    checkOutput("ignore_wre", VW'(vector_wre_out), VW'(1'b1));
    checkOutput("ignore_rd", VW'(vector_rd_out), VW'(5'd5));
    checkOutput("ignore_vec", vector_data_out, 128'h3F3E3D3C3B3A39383736353433323130);
    repeat (2) @(negedge clk);
    checkOutput("ignore_no_refetch", VW'(mem_read_en), '0);

    $display("[TB] back-to-back");
    start        = 1'b1;
    base_address = 12'h200;
    rd_in        = 5'd9;
    @(negedge clk);
    wre_cnt = 0;
    for (int c = 1; c <= 37; c++) begin
      if (vector_wre_out) wre_cnt++;
      if (c == 18) checkOutput("b2b_wre_18", VW'(vector_wre_out), VW'(1'b1));
      if (c == 19) checkOutput("b2b_idle_19", VW'(busy), '0);
      if (c == 20) checkOutput("b2b_addr_20", VW'(mem_address), VW'(12'h300));
      if (c == 37) checkOutput("b2b_wre_37", VW'(vector_wre_out), VW'(1'b1));
      if (c == 19) base_address = 12'h300;
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput("b2b_wre_count", VW'(wre_cnt), VW'(2));

    $display("[TB] reset mid-load");
    for (int i = 0; i < LANES; i++) ram[12'h040 + i] = 8'h50 + LW'(i);
    applyStimulus(12'h040, 5'd12);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checkOutput("rst_busy", VW'(busy), '0);
    checkOutput("rst_data", vector_data_out, '0);
    wre_cnt = 0;
    repeat (20) begin
      if (vector_wre_out) wre_cnt++;
      @(negedge clk);
    end
    checkOutput("rst_no_writeback", VW'(wre_cnt), '0);
    applyStimulus(12'h040, 5'd12);
    repeat (17) @(negedge clk);
    checkOutput("rst_reload_rd", VW'(vector_rd_out), VW'(5'd12));
    checkOutput("rst_reload_vec", vector_data_out, 128'h5F5E5D5C5B5A59585756555453525150);
    @(negedge clk);

    $display("[TB] random traffic");
    for (int n = 0; n < 800; n++) begin
      start        = ($urandom_range(0, 2) == 0);
      base_address = AW'($urandom);
      rd_in        = 5'($urandom);
      reset        = ($urandom_range(0, 149) != 0);
      @(negedge clk);
    end
    reset = 1'b1;
    start = 1'b0;
    repeat (25) @(negedge clk);
    check_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
